// File: rtl/pingpong_reader.sv
// pingpong_reader: read-side controller for a two-bank ping-pong layer buffer.
// Drains banks in order 0,1,0,... through a 3-entry output FIFO with read credits.
module pingpong_reader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_release,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              bank_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  // state   | meaning
  // S_WAIT  | idle, waiting for bank_full[cur]
  // S_READ  | issuing sequential reads while credit allows
  // S_FLUSH | all reads issued, draining until the out_last handshake
  typedef enum logic [1:0] {S_WAIT, S_READ, S_FLUSH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic              r_cur;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [1:0]        r_release;
  logic [DATA_W:0]   r_fifo [4];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [1:0]        r_count;

  logic              w_rd_en;
  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic [2:0]        w_credit;

  // The in-flight read already owns a FIFO slot, so it is counted as occupied.
  assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_rd_en     = (r_state == S_READ) && (w_credit < 3'd3);
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_head_last = r_fifo[r_rptr][DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_WAIT;
      r_cur           <= 1'b0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_release       <= 2'b00;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && (r_addr == LAST_ADDR);
      r_release       <= 2'b00;
      case (r_state)
        S_WAIT: begin
          if (bank_full[r_cur]) begin
            r_state <= S_READ;
            r_addr  <= '0;
          end
        end
        S_READ: begin
          if (w_rd_en) begin
            if (r_addr == LAST_ADDR) r_state <= S_FLUSH;
            else                     r_addr  <= r_addr + 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_pop && w_head_last) begin
            r_state   <= S_WAIT;
            r_cur     <= ~r_cur;
            r_release <= r_cur ? 2'b10 : 2'b01;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {r_inflight_last, rd_data};
        r_wptr         <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_en        = w_rd_en;
  assign rd_addr      = r_addr;
  assign bank_sel     = r_cur;
  assign bank_release = r_release;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo[r_rptr][DATA_W-1:0];
  assign out_last     = (r_count != 2'd0) && w_head_last;
  assign busy         = (r_state != S_WAIT);

endmodule

// File: tb/tb_pingpong_reader.sv
// tb_pingpong_reader: random/directed bench for pingpong_reader with a RAM/writer model
// and a scoreboard that tracks bank order, word order, credits and release pulses.
module tb_pingpong_reader;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int DW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    bank_full, bank_release;
  logic          rd_en, bank_sel, out_valid, out_ready, out_last, busy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;

  logic [1:0]    s_full, s_release;
  logic          s_rd_en, s_sel, s_valid, s_last, s_busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rdata, s_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram   [2][DEPTH];
  logic [DW-1:0] s_ram [2][2];

  pingpong_reader #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bank_full(bank_full), .bank_release(bank_release),
    .rd_en(rd_en), .rd_addr(rd_addr), .bank_sel(bank_sel), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  pingpong_reader #(.ADDR_W(AW), .DEPTH(2), .DATA_W(DW)) dut_small (
    .clk(clk), .rst(rst), .bank_full(s_full), .bank_release(s_release),
    .rd_en(s_rd_en), .rd_addr(s_addr), .bank_sel(s_sel), .rd_data(s_rdata),
    .out_valid(s_valid), .out_ready(1'b1), .out_data(s_data),
    .out_last(s_last), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_bank(input int b);
    for (int i = 0; i < DEPTH; i++) ram[b][i] = DW'($urandom);
  endtask

  // 1-cycle-latency bank RAMs
  initial begin rd_data = '0; s_rdata = '0; end
  always @(posedge clk) if (rd_en)   rd_data <= ram[bank_sel][rd_addr];
  always @(posedge clk) if (s_rd_en) s_rdata <= s_ram[s_sel][s_addr[0]];

  // writer model: clears full on release, refills after a random delay when enabled
  logic wr_auto = 1'b0;
  int   tmr [2];
  initial begin
    tmr[0] = 0; tmr[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++) begin
        if (bank_release[b]) begin
          bank_full[b] = 1'b0;
          tmr[b] = $urandom_range(1, 6);
        end else if (wr_auto && !bank_full[b] && tmr[b] > 0) begin
          tmr[b]--;
          if (tmr[b] == 0) begin
            fill_bank(b);
            bank_full[b] = 1'b1;
          end
        end
      end
    end
  end

  // scoreboard
  int            m_idx, m_rd_idx, m_out, n_words, n_rel, n_rd;
  logic          m_cur, turn_pend, stalled_prev, prev_last;
  logic [1:0]    exp_rel;
  logic [DW-1:0] prev_data;

  initial begin n_words = 0; n_rel = 0; n_rd = 0; end

  always @(negedge clk) begin
    if (!rst) begin
      m_idx = 0; m_rd_idx = 0; m_out = 0; m_cur = 1'b0;
      exp_rel = 2'b00; turn_pend = 1'b0; stalled_prev = 1'b0;
    end else begin
      chk("bank_release", 32'(bank_release), 32'(exp_rel));
      chk("bank_sel", 32'(bank_sel), 32'(m_cur));
      if (turn_pend) chk("turnaround_rd_en", 32'(rd_en), 32'd1);
      turn_pend = (exp_rel != 2'b00) && bank_full[m_cur];
      chk("outstanding_le3", 32'(m_out <= 3), 32'd1);
      if (m_out >= 3) chk("credit_stall", 32'(rd_en), 32'd0);
      if (stalled_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(m_rd_idx));
        m_rd_idx = (m_rd_idx == DEPTH - 1) ? 0 : m_rd_idx + 1;
        m_out++;
        n_rd++;
      end
      exp_rel = 2'b00;
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(ram[m_cur][m_idx]));
        chk("out_last", 32'(out_last), 32'(m_idx == DEPTH - 1));
        m_out--;
        n_words++;
        if (m_idx == DEPTH - 1) begin
          exp_rel = m_cur ? 2'b10 : 2'b01;
          m_cur   = ~m_cur;
          m_idx   = 0;
          n_rel++;
        end else begin
          m_idx++;
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_ov, s_words, s_rel_cycles, s_addr_ok, found, r0;
    logic [DW-1:0] s_got [2];
    logic [1:0]    s_lst;
    logic [1:0]    s_rel_val;

    rst = 1'b0; bank_full = 2'b00; out_ready = 1'b0; s_full = 2'b00;
    fill_bank(0); fill_bank(1);
    for (int b = 0; b < 2; b++) for (int i = 0; i < 2; i++) s_ram[b][i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_release", 32'(bank_release), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b1;

    // only the non-current bank full: must stay idle
    @(posedge clk); #1;
    bank_full = 2'b10;
    n_rd = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_reads", 32'(n_rd), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_bank_sel", 32'(bank_sel), 32'd0);

    // DEPTH=2 instance
    s_full = 2'b01; s_words = 0; s_rel_cycles = 0; s_addr_ok = 0; s_rel_val = 2'b00;
    s_lst = 2'b00; s_got[0] = '0; s_got[1] = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s_rd_en) begin
        if (32'(s_addr) == 32'(s_addr_ok)) s_addr_ok++;
      end
      if (s_valid) begin
        if (s_words < 2) begin
          s_got[s_words] = s_data;
          s_lst[s_words] = s_last;
        end
        s_words++;
      end
      if (s_release != 2'b00) begin
        s_rel_cycles++;
        s_rel_val = s_release;
        s_full = 2'b00;
      end
    end
    chk("d2_words", 32'(s_words), 32'd2);
    chk("d2_addr_seq", 32'(s_addr_ok), 32'd2);
    chk("d2_data0", 32'(s_got[0]), 32'(s_ram[0][0]));
    chk("d2_data1", 32'(s_got[1]), 32'(s_ram[0][1]));
    chk("d2_last", 32'(s_lst), 32'd2);
    chk("d2_release_width", 32'(s_rel_cycles), 32'd1);
    chk("d2_release_val", 32'(s_rel_val), 32'd1);
    chk("d2_bank_sel", 32'(s_sel), 32'd1);

    // latency and back-to-back drain of both banks
    out_ready = 1'b1;
    @(posedge clk); #1;
    bank_full[0] = 1'b1;
    first_rd = -1; first_ov = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_en && first_rd < 0) first_rd = i;
      if (out_valid && first_ov < 0) first_ov = i;
    end
    chk("lat_rd_en", 32'(first_rd), 32'd1);
    chk("lat_out_valid", 32'(first_ov), 32'd3);
    for (int i = 0; i < 1500 && n_rel < 2; i++) @(negedge clk);
    chk("b2b_releases", 32'(n_rel), 32'd2);
    chk("b2b_words", 32'(n_words), 32'(2 * DEPTH));

    // random backpressure with an autonomous writer
    wr_auto = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (busy && m_rd_idx > 0 && m_rd_idx < 200) found = 1;
    end
    chk("stall_found_read", 32'(found), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_outstanding", 32'(m_out), 32'd3);
    chk("stall_rd_en", 32'(rd_en), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // asynchronous reset in the middle of a bank
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (busy && m_idx > 10 && m_idx < 200) found = 1;
    end
    chk("reset_found_read", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_release", 32'(bank_release), 32'd0);
    chk("mid_rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("post_rst_bank_sel", 32'(bank_sel), 32'd0);
    r0 = n_rel;
    for (int i = 0; i < 4000 && n_rel < r0 + 2; i++) @(negedge clk);
    chk("post_rst_releases", 32'(n_rel - r0), 32'd2);

    wr_auto = 1'b0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
